bennett_adder_seq: RTL and testbench
====================================

BENNETT_ADDER_SEQ -- requirements
Module: bennett_adder_seq

Interface
- REQ-001: Parameter WIDTH, default 16, operand/result width in bits; legal range 1..64.
- REQ-002: Parameter STAGES, default 8, number of Bennett clock phase pairs; legal range 1..32.
- REQ-003: Parameter HOLD_CYCLES, default 1, result-hold duration in cycles; legal range 1..255.
- REQ-004: clk  input  1  single system clock; all state updates on the rising edge.
- REQ-005: reset  input  1  asynchronous, active-high reset.
- REQ-006: start  input  1  operation request; sampled only in IDLE.
- REQ-007: ready  output  1  high exactly when state is IDLE.
- REQ-008: a  input  WIDTH  operand A; latched on start acceptance.
- REQ-009: b  input  WIDTH  operand B; latched on start acceptance.
- REQ-010: cin  input  1  carry-in; latched on start acceptance.
- REQ-011: out  output  WIDTH  registered sum.
- REQ-012: cout  output  1  registered carry-out.
- REQ-013: clkp  output  STAGES  positive Bennett phase rails; bit k is stage k.
- REQ-014: clkn  output  STAGES  complement rails; always the bitwise inverse of clkp.
- REQ-015: calculation_done  output  1  high while out/cout hold a valid result (HOLD state).
- REQ-016: busy  output  1  inverse of ready.

Function
- REQ-017: FSM states are IDLE, CHARGE, HOLD and DISCHARGE, each encoded and registered explicitly.
- REQ-018: On the edge where state is IDLE and start=1, the block latches a, b and cin, and state goes to CHARGE with clkp=1 (one bit set).
- REQ-019: In CHARGE, each edge sets the next higher clkp bit, so clkp is a thermometer code; after the edge that sets bit STAGES-1, state becomes HOLD.
- REQ-020: On the CHARGE->HOLD edge, {cout,out} loads the (WIDTH+1)-bit sum A+B+cin of the latched operands, and calculation_done rises.
- REQ-021: HOLD lasts exactly HOLD_CYCLES cycles with clkp all ones; a down-counter sized to HOLD_CYCLES provides the timing.
- REQ-022: In DISCHARGE, each edge clears the highest set clkp bit; the edge that clears bit 0 returns the state to IDLE.
- REQ-023: calculation_done falls on the HOLD->DISCHARGE edge.
- REQ-024: out and cout retain their value outside HOLD until the next CHARGE->HOLD edge.
- REQ-025: Start acceptance to calculation_done rising is STAGES cycles; busy duration is 2*STAGES+HOLD_CYCLES cycles.
- REQ-026: start outside IDLE is ignored and not queued.
- REQ-027: Operand changes after acceptance do not affect the result.
- REQ-028: A start held high continuously is accepted on every cycle in which the block is in IDLE.
- REQ-029: When STAGES=1, CHARGE and DISCHARGE each last one cycle.

Reset
- REQ-030: reset asserted forces, asynchronously: state=IDLE, clkp=0, clkn=all ones, out=0, cout=0, calculation_done=0, busy=0, ready=1, latched operands=0, hold counter=0.
- REQ-031: Reset mid-operation, in any state, aborts the operation and no partial result is presented.
- REQ-032: The first start is accepted on the first rising edge after reset deasserts.

Configuration
- REQ-033: With macro BENNETT_ADDER_SUB_EN defined, the block adds input port sub (1 bit, latched with the operands).
- REQ-034: With BENNETT_ADDER_SUB_EN defined and sub=1, the block computes A + ~B + 1 and ignores cin; cout=1 means no borrow.
- REQ-035: With BENNETT_ADDER_SUB_EN undefined, the sub port and its logic are absent, and the block only adds.

Verification
- REQ-036: Defaults, start with a=0xFFFF, b=0x0001, cin=0 -> clkp goes 0x01,0x03,…,0xFF; on cycle 8, out=0x0000, cout=1, calculation_done=1 for 1 cycle; clkp then goes 0x7F…0x00; ready returns on cycle 17.
- REQ-037: a=0x1234, b=0x4321, cin=1, then a and b changed to 0 during CHARGE -> out=0x5556, cout=0.
- REQ-038: start pulsed during HOLD and during DISCHARGE -> ignored; exactly one calculation_done window; ready after 17 cycles.
- REQ-039: reset asserted during CHARGE with clkp=0x07 -> clkp=0x00, clkn=0xFF and out=0 immediately; next start completes normally.
- REQ-040: WIDTH=8, STAGES=3, HOLD_CYCLES=4, a=0x80, b=0x80 -> out=0x00, cout=1, done high 4 cycles, busy 10 cycles.
- REQ-041: BENNETT_ADDER_SUB_EN defined, a=0x0005, b=0x0007, sub=1, cin=1 -> out=0xFFFE, cout=0.

Source files
------------

// File: rtl/bennett_adder_seq_if.sv
// Bus bundle for bennett_adder_seq: the operation request, operands, result
// and the Bennett phase rails. The optional subtract control (macro
// BENNETT_ADDER_SUB_EN) only exists when that macro is defined.
`timescale 1ns/1ps
interface bennett_adder_seq_if #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 8
);
   logic              start;
   logic              ready;
   logic [WIDTH-1:0]  a;
   logic [WIDTH-1:0]  b;
   logic              cin;
`ifdef BENNETT_ADDER_SUB_EN
   logic              sub;
`endif
   logic [WIDTH-1:0]  out;
   logic              cout;
   logic [STAGES-1:0] clkp;
   logic [STAGES-1:0] clkn;
   logic              calculation_done;
   logic              busy;

   modport master (
      output start, a, b, cin,
`ifdef BENNETT_ADDER_SUB_EN
      output sub,
`endif
      input  ready, out, cout, clkp, clkn, calculation_done, busy
   );

   modport slave (
      input  start, a, b, cin,
`ifdef BENNETT_ADDER_SUB_EN
      input  sub,
`endif
      output ready, out, cout, clkp, clkn, calculation_done, busy
   );
endinterface

// File: rtl/bennett_adder_seq.sv
// Sequential adder sequenced like a Bennett-clocked adiabatic pipeline:
// the phase rails charge one stage per cycle, the sum is captured when the
// last stage charges, held for HOLD_CYCLES, then the rails discharge from
// the top stage down. Optional macro BENNETT_ADDER_SUB_EN adds a subtract
// control (A + ~B + 1, cin ignored) latched together with the operands.
`timescale 1ns/1ps
module bennett_adder_seq #(
   parameter int WIDTH       = 16,
   parameter int STAGES      = 8,
   parameter int HOLD_CYCLES = 1
) (
   input  logic               clk,
   input  logic               reset,
   bennett_adder_seq_if.slave bus
);

   // Hold counter counts HOLD_CYCLES-1 down to 0.
   localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HCW-1:0]    HOLD_LOAD = HCW'(HOLD_CYCLES - 1);
   localparam logic [STAGES-1:0] RAIL_LSB  = STAGES'(1);
   localparam logic [STAGES-1:0] RAIL_FULL = '1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      CHARGE    = 2'd1,
      HOLD      = 2'd2,
      DISCHARGE = 2'd3
   } state_t;

   function automatic logic [WIDTH:0] full_add(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic             c);
      return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
   endfunction

   state_t            state_q, state_d;
   logic [STAGES-1:0] clkp_q, clkp_d;
   logic [HCW-1:0]    hold_q, hold_d;
   logic              accept;
   logic              load_sum;

   logic [WIDTH-1:0]  a_q, b_q;
   logic              cin_q;
   logic [WIDTH-1:0]  out_q;
   logic              cout_q;
   logic [WIDTH-1:0]  b_eff;
   logic              c_eff;

`ifdef BENNETT_ADDER_SUB_EN
   logic              sub_q;

   assign b_eff = sub_q ? ~b_q : b_q;
   assign c_eff = sub_q ? 1'b1 : cin_q;
`else
   assign b_eff = b_q;
   assign c_eff = cin_q;
`endif

   // Next-state logic: rail thermometer walks up in CHARGE, down in DISCHARGE.
   always_comb begin
      state_d  = state_q;
      clkp_d   = clkp_q;
      hold_d   = hold_q;
      accept   = 1'b0;
      load_sum = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               accept  = 1'b1;
               state_d = CHARGE;
               clkp_d  = RAIL_LSB;
            end
         end
         CHARGE: begin
            if (clkp_q[STAGES-1]) begin
               state_d  = HOLD;
               load_sum = 1'b1;
               hold_d   = HOLD_LOAD;
            end else begin
               clkp_d = (clkp_q << 1) | RAIL_LSB;
            end
         end
         HOLD: begin
            clkp_d = RAIL_FULL;
            if (hold_q == '0) begin
               state_d = DISCHARGE;
            end else begin
               hold_d = hold_q - HCW'(1);
            end
         end
         DISCHARGE: begin
            clkp_d = clkp_q >> 1;
            if (clkp_q == RAIL_LSB) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            clkp_d  = '0;
         end
      endcase
   end

   // Control state: FSM, phase rails and hold counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         clkp_q  <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         clkp_q  <= clkp_d;
         hold_q  <= hold_d;
      end
   end

   // Operand capture on acceptance and result capture on entry to HOLD.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q    <= '0;
         b_q    <= '0;
         cin_q  <= 1'b0;
`ifdef BENNETT_ADDER_SUB_EN
         sub_q  <= 1'b0;
`endif
         out_q  <= '0;
         cout_q <= 1'b0;
      end else begin
         if (accept) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            cin_q <= bus.cin;
`ifdef BENNETT_ADDER_SUB_EN
            sub_q <= bus.sub;
`endif
         end
         if (load_sum) begin
            {cout_q, out_q} <= full_add(a_q, b_eff, c_eff);
         end
      end
   end

   assign bus.ready            = (state_q == IDLE);
   assign bus.busy             = (state_q != IDLE);
   assign bus.calculation_done = (state_q == HOLD);
   assign bus.clkp             = clkp_q;
   assign bus.clkn             = ~clkp_q;
   assign bus.out              = out_q;
   assign bus.cout             = cout_q;

endmodule

// File: tb/tb_bennett_adder_seq.sv
// Bench for bennett_adder_seq: default configuration plus a small
// WIDTH=8/STAGES=3/HOLD_CYCLES=4 instance. Expected sums go into a queue
// when a start is accepted and are popped when calculation_done rises.
`timescale 1ns/1ps
module tb_bennett_adder_seq;

   localparam int W0 = 16, S0 = 8, H0 = 1;
   localparam int W1 = 8,  S1 = 3, H1 = 4;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   bennett_adder_seq_if #(.WIDTH(W0), .STAGES(S0)) bus0 ();
   bennett_adder_seq_if #(.WIDTH(W1), .STAGES(S1)) bus1 ();

   bennett_adder_seq #(.WIDTH(W0), .STAGES(S0), .HOLD_CYCLES(H0)) dut0 (
      .clk(clk), .reset(reset), .bus(bus0));
   bennett_adder_seq #(.WIDTH(W1), .STAGES(S1), .HOLD_CYCLES(H1)) dut1 (
      .clk(clk), .reset(reset), .bus(bus1));

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [16:0] sum;
   } vec_t;

   vec_t        vecs [10];
   logic [W0:0] exp_q [$];
   logic [W0:0] last_sum;
   logic [S0-1:0] trace [0:63];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Wait for ready, present one request and record its expected sum.
   task automatic accept0(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic [16:0] sum, input bit keep);
      int guard = 0;
      @(negedge clk);
      while (!bus0.ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("ready_before_start", bus0.ready, 1);
      bus0.start = 1'b1;
      bus0.a     = a;
      bus0.b     = b;
      bus0.cin   = cin;
      exp_q.push_back(sum);
      last_sum = sum;
      @(posedge clk);
      #1;
      if (!keep) begin
         bus0.start = 1'b0;
         bus0.a     = 16'($urandom);
         bus0.b     = 16'($urandom);
         bus0.cin   = 1'($urandom);
      end
   endtask

   // Follow one operation from the cycle after acceptance back to idle.
   task automatic track0(input bit pulse_hold, input bit pulse_dis, input bit keep,
                         output int lat, output int dlen, output int blen, output bit ok);
      int i;
      bit seen_done, prev_done, pulsed_dis;
      logic [W0:0] e;
      seen_done = 0; prev_done = 0; pulsed_dis = 0;
      lat = -1; dlen = 0; blen = 0; ok = 1;
      for (i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (i < 64) trace[i] = bus0.clkp;
         if (bus0.clkn !== ~bus0.clkp) ok = 0;
         if (bus0.busy !== ~bus0.ready) ok = 0;
         if (!keep) bus0.start = 1'b0;
         if (!bus0.busy) break;
         blen++;
         if (bus0.calculation_done) begin
            dlen++;
            if (!prev_done) begin
               lat = i - 1;
               seen_done = 1;
               if (bus0.clkp !== '1) ok = 0;
               if (exp_q.size() == 0) begin
                  check("scoreboard_underflow", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("sum", {bus0.cout, bus0.out}, e);
               end
            end
            if (pulse_hold) bus0.start = 1'b1;
         end else if (seen_done && pulse_dis && !pulsed_dis) begin
            bus0.start = 1'b1;
            pulsed_dis = 1;
         end
         prev_done = bus0.calculation_done;
      end
      if (i > 200) check("op_timeout", 0, 1);
      if (!keep) bus0.start = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, dlen, blen, lat1, d1, b1;
      bit ok, first;
      logic [S0-1:0] ex;
      logic [W1:0]   sum1;

      vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 17'h10000};
      vecs[1] = '{16'h1234, 16'h4321, 1'b1, 17'h05556};
      vecs[2] = '{16'h0000, 16'h0000, 1'b0, 17'h00000};
      vecs[3] = '{16'h0000, 16'h0000, 1'b1, 17'h00001};
      vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF};
      vecs[5] = '{16'h8000, 16'h8000, 1'b0, 17'h10000};
      vecs[6] = '{16'h7FFF, 16'h0001, 1'b0, 17'h08000};
      vecs[7] = '{16'hAAAA, 16'h5555, 1'b0, 17'h0FFFF};
      vecs[8] = '{16'hAAAA, 16'h5555, 1'b1, 17'h10000};
      vecs[9] = '{16'h00FF, 16'hFF01, 1'b0, 17'h10000};

      reset = 1'b1;
      bus0.start = 1'b0; bus0.a = '0; bus0.b = '0; bus0.cin = 1'b0;
      bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
`ifdef BENNETT_ADDER_SUB_EN
      bus0.sub = 1'b0;
      bus1.sub = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("rst_ready", bus0.ready, 1);
      check("rst_busy", bus0.busy, 0);
      check("rst_clkp", bus0.clkp, 8'h00);
      check("rst_clkn", bus0.clkn, 8'hFF);
      check("rst_out", {bus0.cout, bus0.out}, 17'h0);
      check("rst_done", bus0.calculation_done, 0);
      check("rst1_clkn", bus1.clkn, 3'b111);

      // First start right at reset release, with full rail trace.
      reset = 1'b0;
      bus0.start = 1'b1; bus0.a = 16'hFFFF; bus0.b = 16'h0001; bus0.cin = 1'b0;
      exp_q.push_back(17'h10000);
      last_sum = 17'h10000;
      @(posedge clk);
      #1;
      check("first_accept_busy", bus0.busy, 1);
      bus0.start = 1'b0; bus0.a = '0; bus0.b = '0;
      track0(0, 0, 0, lat, dlen, blen, ok);
      check("first_latency", lat, 8);
      check("first_done_len", dlen, 1);
      check("first_busy_len", blen, 17);
      check("first_rails_ok", ok, 1);
      for (int j = 1; j <= 18; j++) begin
         if (j <= 8)       ex = 8'((1 << j) - 1);
         else if (j <= 10) ex = 8'hFF;
         else              ex = 8'hFF >> (j - 10);
         check($sformatf("clkp_trace_%0d", j), trace[j], ex);
      end

      // Table of vectors; operands are scrambled after acceptance.
      for (int j = 1; j < 10; j++) begin
         accept0(vecs[j].a, vecs[j].b, vecs[j].cin, vecs[j].sum, 0);
         track0(0, 0, 0, lat, dlen, blen, ok);
         check($sformatf("vec%0d_latency", j), lat, 8);
         check($sformatf("vec%0d_busy_len", j), blen, 17);
         check($sformatf("vec%0d_done_len", j), dlen, 1);
         check($sformatf("vec%0d_rails_ok", j), ok, 1);
         check($sformatf("vec%0d_retained", j), {bus0.cout, bus0.out}, last_sum);
      end

      // Starts during HOLD and DISCHARGE are ignored.
      accept0(16'h0F0F, 16'h0101, 1'b0, 17'h01010, 0);
      track0(1, 1, 0, lat, dlen, blen, ok);
      check("ignore_done_len", dlen, 1);
      check("ignore_busy_len", blen, 17);
      @(negedge clk);
      check("ignore_not_queued", bus0.busy, 0);
      check("ignore_queue_empty", exp_q.size(), 0);

      // Start held high: accepted again on the single idle cycle.
      accept0(16'h0002, 16'h0003, 1'b0, 17'h00005, 1);
      track0(0, 0, 1, lat, dlen, blen, ok);
      check("held_busy_len", blen, 17);
      check("held_idle_ready", bus0.ready, 1);
      @(posedge clk);
      #1;
      check("held_reaccept", bus0.busy, 1);
      exp_q.push_back(17'h00005);
      bus0.start = 1'b0;
      track0(0, 0, 0, lat, dlen, blen, ok);
      check("held2_busy_len", blen, 17);
      check("held2_latency", lat, 8);

      // Reset in the middle of CHARGE.
      accept0(16'h1111, 16'h2222, 1'b0, 17'h03333, 0);
      first = 0;
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         if (bus0.clkp == 8'h07) begin
            first = 1;
            break;
         end
      end
      check("mid_reset_reached_07", first, 1);
      reset = 1'b1;
      #1;
      check("mid_reset_clkp", bus0.clkp, 8'h00);
      check("mid_reset_clkn", bus0.clkn, 8'hFF);
      check("mid_reset_out", {bus0.cout, bus0.out}, 17'h0);
      check("mid_reset_ready", bus0.ready, 1);
      check("mid_reset_done", bus0.calculation_done, 0);
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
      accept0(16'h1111, 16'h2222, 1'b1, 17'h03334, 0);
      track0(0, 0, 0, lat, dlen, blen, ok);
      check("post_reset_latency", lat, 8);
      check("post_reset_busy_len", blen, 17);

`ifdef BENNETT_ADDER_SUB_EN
      bus0.sub = 1'b1;
      accept0(16'h0005, 16'h0007, 1'b1, 17'h0FFFE, 0);
      bus0.sub = 1'b0;
      track0(0, 0, 0, lat, dlen, blen, ok);
      check("sub_busy_len", blen, 17);
`endif

      // Small instance: WIDTH=8, STAGES=3, HOLD_CYCLES=4.
      @(negedge clk);
      check("small_ready", bus1.ready, 1);
      bus1.start = 1'b1; bus1.a = 8'h80; bus1.b = 8'h80; bus1.cin = 1'b0;
      @(posedge clk);
      #1;
      bus1.start = 1'b0; bus1.a = 8'h00; bus1.b = 8'h00;
      lat1 = -1; d1 = 0; b1 = 0; first = 1; sum1 = '0;
      for (int j = 1; j <= 100; j++) begin
         @(negedge clk);
         if (!bus1.busy) break;
         b1++;
         if (bus1.calculation_done) begin
            d1++;
            if (first) begin
               first = 0;
               lat1 = j - 1;
               sum1 = {bus1.cout, bus1.out};
            end
         end
      end
      check("small_sum", sum1, 9'h100);
      check("small_latency", lat1, 3);
      check("small_done_len", d1, 4);
      check("small_busy_len", b1, 10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
